uvmt_cv32e40s_sl_trigger_hit_tracker: RTL and testbench

//  Support-logic stage downstream of the per-memory-operation trigger match blocks. Combines up to
//  MAX_MEM_ACCESS per-operation match vectors plus execute matches for each retired instruction.

---
 rtl/uvmt_cv32e40s_sl_trigger_hit_tracker.sv | 184 ++++++++++++++++++
 tb/tb_uvmt_cv32e40s_sl_trigger_hit_tracker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uvmt_cv32e40s_sl_trigger_hit_tracker.sv
// ----------------------------------------------------------------------------
// uvmt_cv32e40s_sl_trigger_hit_tracker
//
// Support-logic stage that sits after the per-memory-operation trigger match
// blocks. For every retired instruction it merges the match vectors of all
// memory operations that are actually in use with the execute-address match
// vector. From that it predicts the sticky per-trigger hit flags, counts the
// retirements that carry a qualified trigger match, and checks that the
// retirement following such a match is a debug entry with cause "trigger".
// The outputs feed trigger/debug assertions and functional coverage.
//
// Ports
//   clk_i                  clock
//   rst_i                  synchronous active-high reset
//   rvfi_valid             an instruction retires this cycle
//   rvfi_dbg_mode          the retiring instruction executed in debug mode
//   rvfi_dbg               debug-entry cause of the retirement (2 = trigger)
//   mem_op_valid           one bit per memory operation: operation n in use
//   trigger_match_mem      operation n's match vector sits at n*NUM_TRIGGERS
//   trigger_match_execute  execute-address match vector
//   tdata1_wr              the retirement writes tdata1
//   tdata1_wr_sel          tselect value in effect for that write
//   tdata1_wr_hit          hit bit value carried by that write
//   trigger_hit            sticky predicted hit flag per trigger
//   match_cnt              saturating count of qualified matches
//   pending                waiting for a trigger debug entry
//   dbg_entry_err          one-cycle pulse: expected debug entry missing/wrong
//   timeout_err            one-cycle pulse: no retirement arrived in time
// ----------------------------------------------------------------------------
module uvmt_cv32e40s_sl_trigger_hit_tracker #(
   parameter int NUM_TRIGGERS   = 2,
   parameter int MAX_MEM_ACCESS = 13,
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   rvfi_valid,
   input  logic                                   rvfi_dbg_mode,
   input  logic [2:0]                             rvfi_dbg,
   input  logic [MAX_MEM_ACCESS-1:0]              mem_op_valid,
   input  logic [MAX_MEM_ACCESS*NUM_TRIGGERS-1:0] trigger_match_mem,
   input  logic [NUM_TRIGGERS-1:0]                trigger_match_execute,
   input  logic                                   tdata1_wr,
   input  logic [$clog2(NUM_TRIGGERS):0]          tdata1_wr_sel,
   input  logic                                   tdata1_wr_hit,
   output logic [NUM_TRIGGERS-1:0]                trigger_hit,
   output logic [15:0]                            match_cnt,
   output logic                                   pending,
   output logic                                   dbg_entry_err,
   output logic                                   timeout_err
);

   localparam int SEL_W   = $clog2(NUM_TRIGGERS) + 1;
   localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0] DBG_CAUSE_TRIGGER = 3'd2;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } state_t;

   state_t                   state;
   state_t                   state_next;
   logic [TIMER_W-1:0]       timer;
   logic [TIMER_W-1:0]       timer_next;
   logic                     dbg_entry_err_next;
   logic                     timeout_err_next;
   logic [NUM_TRIGGERS-1:0]  mem_vec;
   logic [NUM_TRIGGERS-1:0]  match_vec;
   logic                     qualified;
   logic                     trigger_entry;
   logic [NUM_TRIGGERS-1:0]  hit_next;
   logic [15:0]              cnt_next;

   // Merge the match vectors of all memory operations that are in use.
   // Operations whose valid bit is low may carry stale match bits from the
   // match blocks, so they are masked out before the OR reduction.
   always_comb begin
      mem_vec = '0;
      for (int n = 0; n < MAX_MEM_ACCESS; n++) begin
         if (mem_op_valid[n]) begin
            mem_vec = mem_vec | trigger_match_mem[n*NUM_TRIGGERS +: NUM_TRIGGERS];
         end
      end
   end

   // A retirement only counts as a trigger match outside debug mode, since
   // triggers are not allowed to fire while the core is already in debug.
   // Execute and memory matches of one retirement form a single match event.
   assign match_vec     = mem_vec | trigger_match_execute;
   assign qualified     = rvfi_valid && !rvfi_dbg_mode && (|match_vec);
   assign trigger_entry = rvfi_dbg_mode && (rvfi_dbg == DBG_CAUSE_TRIGGER);

   // Next value of the sticky hit flags. A tdata1 write to a trigger
   // overrides a hit set by the same retirement, because software owns the
   // architectural value it writes. Selects beyond the implemented triggers
   // never match any index and therefore leave every flag untouched.
   always_comb begin
      hit_next = trigger_hit;
      if (qualified) begin
         hit_next = trigger_hit | match_vec;
      end
      for (int t = 0; t < NUM_TRIGGERS; t++) begin
         if (tdata1_wr && (tdata1_wr_sel == SEL_W'(t))) begin
            hit_next[t] = tdata1_wr_hit;
         end
      end
   end

   // Match counter increments once per qualified retirement and holds at
   // its maximum instead of wrapping, so coverage never sees a false low.
   always_comb begin
      cnt_next = match_cnt;
      if (qualified && (match_cnt != 16'hFFFF)) begin
         cnt_next = match_cnt + 16'd1;
      end
   end

   // Debug-entry expectation FSM. After a qualified match the very next
   // retirement must be a trigger debug entry. A retirement always resolves
   // the expectation, even in the cycle the timer would expire. A wrong
   // retirement that is itself a qualified match re-arms the expectation.
   always_comb begin
      state_next         = state;
      timer_next         = timer;
      dbg_entry_err_next = 1'b0;
      timeout_err_next   = 1'b0;
      unique case (state)
         IDLE: begin
            if (qualified) begin
               state_next = PENDING;
               timer_next = '0;
            end
         end
         PENDING: begin
            if (rvfi_valid) begin
               if (trigger_entry) begin
                  state_next = IDLE;
               end else begin
                  dbg_entry_err_next = 1'b1;
                  if (qualified) begin
                     state_next = PENDING;
                     timer_next = '0;
                  end else begin
                     state_next = IDLE;
                  end
               end
            end else if (timer == TIMER_LAST) begin
               timeout_err_next = 1'b1;
               state_next       = IDLE;
            end else begin
               timer_next = timer + TIMER_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register and all registered outputs. Reset simply discards any
   // outstanding expectation; no error is reported for it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         timer         <= '0;
         trigger_hit   <= '0;
         match_cnt     <= '0;
         dbg_entry_err <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         state         <= state_next;
         timer         <= timer_next;
         trigger_hit   <= hit_next;
         match_cnt     <= cnt_next;
         dbg_entry_err <= dbg_entry_err_next;
         timeout_err   <= timeout_err_next;
      end
   end

   assign pending = (state == PENDING);

endmodule

// File: tb/tb_uvmt_cv32e40s_sl_trigger_hit_tracker.sv
// ----------------------------------------------------------------------------
// tb_uvmt_cv32e40s_sl_trigger_hit_tracker
//
// Directed bench for the trigger hit tracker with NUM_TRIGGERS=2,
// MAX_MEM_ACCESS=13 and TIMEOUT_CYCLES=32. Each stimulus cycle is driven on
// the falling edge together with the hand-computed outputs expected after
// the following rising edge; those expectations are queued and a separate
// monitor compares them one step past every rising edge.
// ----------------------------------------------------------------------------
module tb_uvmt_cv32e40s_sl_trigger_hit_tracker;

   localparam int NT = 2;
   localparam int MA = 13;
   localparam int TO = 32;

   logic             clk_i;
   logic             rst_i;
   logic             rvfi_valid;
   logic             rvfi_dbg_mode;
   logic [2:0]       rvfi_dbg;
   logic [MA-1:0]    mem_op_valid;
   logic [MA*NT-1:0] trigger_match_mem;
   logic [NT-1:0]    trigger_match_execute;
   logic             tdata1_wr;
   logic [1:0]       tdata1_wr_sel;
   logic             tdata1_wr_hit;
   logic [NT-1:0]    trigger_hit;
   logic [15:0]      match_cnt;
   logic             pending;
   logic             dbg_entry_err;
   logic             timeout_err;

   typedef struct {
      int          step;
      logic [1:0]  hit;
      logic [15:0] cnt;
      logic        pend;
      logic        derr;
      logic        terr;
   } exp_t;

   exp_t exp_q[$];
   int   checks;
   int   errors;
   int   step;

   uvmt_cv32e40s_sl_trigger_hit_tracker #(
      .NUM_TRIGGERS   (NT),
      .MAX_MEM_ACCESS (MA),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_i                 (clk_i),
      .rst_i                 (rst_i),
      .rvfi_valid            (rvfi_valid),
      .rvfi_dbg_mode         (rvfi_dbg_mode),
      .rvfi_dbg              (rvfi_dbg),
      .mem_op_valid          (mem_op_valid),
      .trigger_match_mem     (trigger_match_mem),
      .trigger_match_execute (trigger_match_execute),
      .tdata1_wr             (tdata1_wr),
      .tdata1_wr_sel         (tdata1_wr_sel),
      .tdata1_wr_hit         (tdata1_wr_hit),
      .trigger_hit           (trigger_hit),
      .match_cnt             (match_cnt),
      .pending               (pending),
      .dbg_entry_err         (dbg_entry_err),
      .timeout_err           (timeout_err)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Single comparison with failure report.
   task automatic checkOutput(input string name, input int stp,
                              input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL step %0d %s: got %h, expected %h", stp, name, act, req);
      end
   endtask

   // Place a single operation's match vector into the packed mem bus.
   function automatic logic [MA*NT-1:0] memSlice(input int n, input logic [1:0] v);
      logic [MA*NT-1:0] r;
      r = '0;
      r[n*NT +: NT] = v;
      return r;
   endfunction

   // Drive one cycle of inputs and queue the outputs expected after the edge.
   task automatic applyStimulus(
      input logic rst, input logic valid, input logic dmode, input logic [2:0] dbg,
      input logic [MA-1:0] opv, input logic [MA*NT-1:0] mm, input logic [1:0] ex,
      input logic wr, input logic [1:0] sel, input logic wh,
      input logic [1:0] e_hit, input logic [15:0] e_cnt,
      input logic e_pend, input logic e_derr, input logic e_terr);
      exp_t e;
      @(negedge clk_i);
      rst_i                 = rst;
      rvfi_valid            = valid;
      rvfi_dbg_mode         = dmode;
      rvfi_dbg              = dbg;
      mem_op_valid          = opv;
      trigger_match_mem     = mm;
      trigger_match_execute = ex;
      tdata1_wr             = wr;
      tdata1_wr_sel         = sel;
      tdata1_wr_hit         = wh;
      step++;
      e.step = step;
      e.hit  = e_hit;
      e.cnt  = e_cnt;
      e.pend = e_pend;
      e.derr = e_derr;
      e.terr = e_terr;
      exp_q.push_back(e);
   endtask

   task automatic idleCycle(input logic [1:0] e_hit, input logic [15:0] e_cnt,
                            input logic e_pend, input logic e_derr, input logic e_terr);
      applyStimulus(0, 0, 0, 3'd0, '0, '0, 2'b00, 0, 2'd0, 0, e_hit, e_cnt, e_pend, e_derr, e_terr);
   endtask

   task automatic resetCycle();
      applyStimulus(1, 0, 0, 3'd0, '0, '0, 2'b00, 0, 2'd0, 0, 2'b00, 16'd0, 0, 0, 0);
   endtask

   // Retirement that is a trigger debug entry, with no matches.
   task automatic dbgEntry(input logic [1:0] e_hit, input logic [15:0] e_cnt);
      applyStimulus(0, 1, 1, 3'd2, '0, '0, 2'b00, 0, 2'd0, 0, e_hit, e_cnt, 0, 0, 0);
   endtask

   // Monitor: compare queued expectations shortly after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_i);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("trigger_hit", e.step, 16'(trigger_hit), 16'(e.hit));
            checkOutput("match_cnt", e.step, match_cnt, e.cnt);
            checkOutput("pending", e.step, 16'(pending), 16'(e.pend));
            checkOutput("dbg_entry_err", e.step, 16'(dbg_entry_err), 16'(e.derr));
            checkOutput("timeout_err", e.step, 16'(timeout_err), 16'(e.terr));
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus sequence.
   initial begin
      checks = 0;
      errors = 0;
      step   = 0;
      rst_i = 1'b1; rvfi_valid = 1'b0; rvfi_dbg_mode = 1'b0; rvfi_dbg = 3'd0;
      mem_op_valid = '0; trigger_match_mem = '0; trigger_match_execute = '0;
      tdata1_wr = 1'b0; tdata1_wr_sel = 2'd0; tdata1_wr_hit = 1'b0;

      $display("[TB] reset");
      resetCycle();
      resetCycle();

      $display("[TB] op0 match followed by trigger debug entry");
      applyStimulus(0, 1, 0, 3'd0, 13'h0001, memSlice(0, 2'b01), 2'b00, 0, 2'd0, 0,
                    2'b01, 16'd1, 1, 0, 0);
      dbgEntry(2'b01, 16'd1);
      idleCycle(2'b01, 16'd1, 0, 0, 0);

      $display("[TB] push of five ops, op1 not in use");
      resetCycle();
      applyStimulus(0, 1, 0, 3'd0, 13'h001D, memSlice(1, 2'b10), 2'b00, 0, 2'd0, 0,
                    2'b00, 16'd0, 0, 0, 0);
      applyStimulus(0, 1, 0, 3'd0, 13'h001D, memSlice(1, 2'b10) | memSlice(4, 2'b10),
                    2'b00, 0, 2'd0, 0, 2'b10, 16'd1, 1, 0, 0);
      dbgEntry(2'b10, 16'd1);

      $display("[TB] wrong retirement after a match");
      resetCycle();
      applyStimulus(0, 1, 0, 3'd0, '0, '0, 2'b01, 0, 2'd0, 0, 2'b01, 16'd1, 1, 0, 0);
      applyStimulus(0, 1, 0, 3'd0, '0, '0, 2'b00, 0, 2'd0, 0, 2'b01, 16'd1, 0, 1, 0);
      idleCycle(2'b01, 16'd1, 0, 0, 0);
      applyStimulus(0, 1, 0, 3'd0, '0, '0, 2'b01, 0, 2'd0, 0, 2'b01, 16'd2, 1, 0, 0);
      applyStimulus(0, 1, 1, 3'd3, '0, '0, 2'b00, 0, 2'd0, 0, 2'b01, 16'd2, 0, 1, 0);
      idleCycle(2'b01, 16'd2, 0, 0, 0);
      applyStimulus(0, 1, 0, 3'd0, '0, '0, 2'b10, 0, 2'd0, 0, 2'b11, 16'd3, 1, 0, 0);
      applyStimulus(0, 1, 0, 3'd0, '0, '0, 2'b01, 0, 2'd0, 0, 2'b11, 16'd4, 1, 1, 0);
      dbgEntry(2'b11, 16'd4);

      $display("[TB] timeout with op12 match");
      resetCycle();
      applyStimulus(0, 1, 0, 3'd0, 13'h1000, memSlice(12, 2'b01), 2'b00, 0, 2'd0, 0,
                    2'b01, 16'd1, 1, 0, 0);
      for (int i = 1; i <= TO; i++) begin
         idleCycle(2'b01, 16'd1, (i < TO), 0, (i == TO));
      end
      idleCycle(2'b01, 16'd1, 0, 0, 0);

      $display("[TB] retirement in the timeout cycle wins");
      resetCycle();
      applyStimulus(0, 1, 0, 3'd0, 13'h0001, memSlice(0, 2'b10), 2'b00, 0, 2'd0, 0,
                    2'b10, 16'd1, 1, 0, 0);
      for (int i = 1; i < TO; i++) begin
         idleCycle(2'b10, 16'd1, 1, 0, 0);
      end
      dbgEntry(2'b10, 16'd1);
      idleCycle(2'b10, 16'd1, 0, 0, 0);

      $display("[TB] tdata1 writes");
      resetCycle();
      applyStimulus(0, 1, 0, 3'd0, '0, '0, 2'b11, 0, 2'd0, 0, 2'b11, 16'd1, 1, 0, 0);
      applyStimulus(0, 1, 0, 3'd0, '0, '0, 2'b10, 1, 2'd1, 0, 2'b01, 16'd2, 1, 1, 0);
      applyStimulus(0, 1, 1, 3'd2, '0, '0, 2'b00, 1, 2'd2, 0, 2'b01, 16'd2, 0, 0, 0);
      applyStimulus(0, 0, 0, 3'd0, '0, '0, 2'b00, 1, 2'd3, 1, 2'b01, 16'd2, 0, 0, 0);
      applyStimulus(0, 0, 0, 3'd0, '0, '0, 2'b00, 1, 2'd0, 0, 2'b00, 16'd2, 0, 0, 0);
      applyStimulus(0, 0, 0, 3'd0, '0, '0, 2'b00, 1, 2'd1, 1, 2'b10, 16'd2, 0, 0, 0);

      $display("[TB] debug mode match and reset while pending");
      resetCycle();
      applyStimulus(0, 1, 1, 3'd0, 13'h0003, memSlice(1, 2'b11), 2'b11, 0, 2'd0, 0,
                    2'b00, 16'd0, 0, 0, 0);
      applyStimulus(0, 1, 0, 3'd0, '0, '0, 2'b01, 0, 2'd0, 0, 2'b01, 16'd1, 1, 0, 0);
      resetCycle();
      idleCycle(2'b00, 16'd0, 0, 0, 0);

      @(negedge clk_i);
      @(negedge clk_i);
      checkOutput("queue_drained", step, 16'(exp_q.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
